// File: rtl/gyro_rd_pkg.sv
// rtl/gyro_rd_pkg.sv - states, SPI command words and decode helpers for gyro_rd_ctrl (GYRO_RD_YAW_EN adds yaw states)
package gyro_rd_pkg;

    typedef enum logic [4:0] {
        S_PWRUP  = 5'd0,
        S_CFG0,
        S_CFG0_W,
        S_CFG1,
        S_CFG1_W,
        S_CFG2,
        S_CFG2_W,
        S_IDLE,
        S_RDL,
        S_RDL_W,
        S_RDH,
        S_RDH_W,
`ifdef GYRO_RD_YAW_EN
        S_YAWL,
        S_YAWL_W,
        S_YAWH,
        S_YAWH_W,
`endif
        S_VLD
    } state_t;

    localparam logic [15:0] CMD_INT_CFG = 16'h0D02;
    localparam logic [15:0] CMD_G_ODR   = 16'h1160;
    localparam logic [15:0] CMD_CTRL    = 16'h1440;
    localparam logic [15:0] CMD_PTCHL   = 16'hA200;
    localparam logic [15:0] CMD_PTCHH   = 16'hA300;
    localparam logic [15:0] CMD_YAWL    = 16'hA600;
    localparam logic [15:0] CMD_YAWH    = 16'hA700;

    function automatic logic is_issue(input state_t s);
        case (s)
            S_CFG0, S_CFG1, S_CFG2, S_RDL, S_RDH: is_issue = 1'b1;
`ifdef GYRO_RD_YAW_EN
            S_YAWL, S_YAWH:                       is_issue = 1'b1;
`endif
            default:                              is_issue = 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] issue_cmd(input state_t s);
        case (s)
            S_CFG0:  issue_cmd = CMD_INT_CFG;
            S_CFG1:  issue_cmd = CMD_G_ODR;
            S_CFG2:  issue_cmd = CMD_CTRL;
            S_RDL:   issue_cmd = CMD_PTCHL;
            S_RDH:   issue_cmd = CMD_PTCHH;
`ifdef GYRO_RD_YAW_EN
            S_YAWL:  issue_cmd = CMD_YAWL;
            S_YAWH:  issue_cmd = CMD_YAWH;
`endif
            default: issue_cmd = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - two-flop synchronizer for the sensor data-ready interrupt
module int_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gyro_rd_ctrl.sv
// rtl/gyro_rd_ctrl.sv - iNEMO configure/read sequencer driving SPI_mnrch; GYRO_RD_YAW_EN adds yaw readout
module gyro_rd_ctrl
    import gyro_rd_pkg::*;
#(
    parameter int PWRUP_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               INT,
    input  logic               done,
    input  logic [15:0]        resp,
    output logic               snd,
    output logic [15:0]        cmd,
    output logic signed [15:0] ptch,
    output logic               vld
`ifdef GYRO_RD_YAW_EN
    ,
    output logic [15:0]        yaw
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic [PWRUP_W-1:0] pwrup_cnt;
    logic               int_s;
    logic [7:0]         ptch_lo;
    logic [7:0]         ptch_hi;
`ifdef GYRO_RD_YAW_EN
    logic [7:0]         yaw_lo;
    logic [7:0]         yaw_hi;
`endif
    logic               unused_resp_hi;

    assign unused_resp_hi = ^resp[15:8];

    int_sync u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (INT),
        .q   (int_s)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_PWRUP:  if (&pwrup_cnt) state_nxt = S_CFG0;
            S_CFG0:   state_nxt = S_CFG0_W;
            S_CFG0_W: if (done) state_nxt = S_CFG1;
            S_CFG1:   state_nxt = S_CFG1_W;
            S_CFG1_W: if (done) state_nxt = S_CFG2;
            S_CFG2:   state_nxt = S_CFG2_W;
            S_CFG2_W: if (done) state_nxt = S_IDLE;
            S_IDLE:   if (int_s) state_nxt = S_RDL;
            S_RDL:    state_nxt = S_RDL_W;
            S_RDL_W:  if (done) state_nxt = S_RDH;
            S_RDH:    state_nxt = S_RDH_W;
`ifdef GYRO_RD_YAW_EN
            S_RDH_W:  if (done) state_nxt = S_YAWL;
            S_YAWL:   state_nxt = S_YAWL_W;
            S_YAWL_W: if (done) state_nxt = S_YAWH;
            S_YAWH:   state_nxt = S_YAWH_W;
            S_YAWH_W: if (done) state_nxt = S_VLD;
`else
            S_RDH_W:  if (done) state_nxt = S_VLD;
`endif
            S_VLD:    state_nxt = S_IDLE;
            default:  state_nxt = S_PWRUP;
        endcase
    end

    // snd, cmd and vld are registered from the next state so each is high
    // exactly while the FSM sits in the corresponding issue / VLD state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_PWRUP;
            pwrup_cnt <= '0;
            snd       <= 1'b0;
            cmd       <= 16'h0000;
            ptch      <= 16'sh0000;
            vld       <= 1'b0;
            ptch_lo   <= 8'h00;
            ptch_hi   <= 8'h00;
`ifdef GYRO_RD_YAW_EN
            yaw       <= 16'h0000;
            yaw_lo    <= 8'h00;
            yaw_hi    <= 8'h00;
`endif
        end else begin
            state <= state_nxt;
            snd   <= is_issue(state_nxt);
            vld   <= (state_nxt == S_VLD);
            if (is_issue(state_nxt)) begin
                cmd <= issue_cmd(state_nxt);
            end
            if (state == S_PWRUP && !(&pwrup_cnt)) begin
                pwrup_cnt <= pwrup_cnt + 1'b1;
            end
            if (done) begin
                case (state)
                    S_RDL_W:  ptch_lo <= resp[7:0];
                    S_RDH_W:  ptch_hi <= resp[7:0];
`ifdef GYRO_RD_YAW_EN
                    S_YAWL_W: yaw_lo  <= resp[7:0];
                    S_YAWH_W: yaw_hi  <= resp[7:0];
`endif
                    default:  ;
                endcase
            end
            // The last byte is taken straight from resp so ptch lands on the vld edge.
`ifdef GYRO_RD_YAW_EN
            if (state == S_YAWH_W && done) begin
                ptch <= {ptch_hi, ptch_lo};
                yaw  <= {resp[7:0], yaw_lo};
            end
`else
            if (state == S_RDH_W && done) begin
                ptch <= {resp[7:0], ptch_lo};
            end
`endif
        end
    end

endmodule

// File: tb/tb_gyro_rd_ctrl.sv
// tb/tb_gyro_rd_ctrl.sv - directed self-checking bench for gyro_rd_ctrl with an SPI/iNEMO responder model
module tb_gyro_rd_ctrl;
    import gyro_rd_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               INT;
    logic               done;
    logic [15:0]        resp;
    logic               snd;
    logic [15:0]        cmd;
    logic signed [15:0] ptch;
    logic               vld;
`ifdef GYRO_RD_YAW_EN
    logic [15:0]        yaw;
    localparam int          NRD      = 4;
    localparam logic [15:0] LAST_CMD = 16'hA700;
`else
    localparam int          NRD      = 2;
    localparam logic [15:0] LAST_CMD = 16'hA300;
`endif

    int errors = 0;
    int checks = 0;

    logic        busy;
    logic        stall = 1'b0;
    logic        nemo_setup;
    int          lat;
    logic [15:0] cur_cmd;
    logic [15:0] rsp_val;
    logic [7:0]  lo_val = 8'h00;
    logic [7:0]  hi_val = 8'h00;
    logic [7:0]  yl_val = 8'h00;
    logic [7:0]  yh_val = 8'h00;

    int          ncyc = 0;
    int          last_done_cyc = 0;
    int          snd_pulses = 0;
    int          vld_pulses = 0;
    int          snd_long = 0;
    int          vld_long = 0;
    int          bad_snd_gap = 0;
    int          bad_vld_gap = 0;
    logic        prev_snd = 1'b0;
    logic        prev_vld = 1'b0;
    logic        had_done = 1'b0;
    logic [15:0] cmd_log[$];

    always #5 clk = ~clk;

    gyro_rd_ctrl #(.PWRUP_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .INT  (INT),
        .done (done),
        .resp (resp),
        .snd  (snd),
        .cmd  (cmd),
        .ptch (ptch),
        .vld  (vld)
`ifdef GYRO_RD_YAW_EN
        ,
        .yaw  (yaw)
`endif
    );

    function automatic logic [15:0] pick(input logic [15:0] c);
        case (c[15:8])
            8'hA2:   pick = {8'hEE, lo_val};
            8'hA3:   pick = {8'hEE, hi_val};
            8'hA6:   pick = {8'hEE, yl_val};
            8'hA7:   pick = {8'hEE, yh_val};
            default: pick = 16'hEE5A;
        endcase
    endfunction

    // SPI_mnrch + sensor stand-in: fixed latency, one-cycle done, junk upper byte
    always @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            busy       <= 1'b0;
            lat        <= 0;
            nemo_setup <= 1'b0;
            resp       <= 16'h0000;
        end else if (busy) begin
            if (!stall) begin
                if (lat == 0) begin
                    done <= 1'b1;
                    resp <= rsp_val;
                    busy <= 1'b0;
                    if (cur_cmd == CMD_INT_CFG) nemo_setup <= 1'b1;
                end else begin
                    lat <= lat - 1;
                end
            end
        end else if (snd) begin
            busy    <= 1'b1;
            lat     <= 3;
            cur_cmd <= cmd;
            rsp_val <= pick(cmd);
        end
    end

    always @(negedge clk) begin
        ncyc     <= ncyc + 1;
        prev_snd <= snd;
        prev_vld <= vld;
        if (done) begin
            last_done_cyc <= ncyc;
            had_done      <= 1'b1;
        end
        if (snd) begin
            cmd_log.push_back(cmd);
            snd_pulses <= snd_pulses + 1;
            if (prev_snd) snd_long <= snd_long + 1;
            if (had_done && cmd != CMD_INT_CFG && cmd != CMD_PTCHL && (ncyc - last_done_cyc) != 1)
                bad_snd_gap <= bad_snd_gap + 1;
        end
        if (vld) begin
            vld_pulses <= vld_pulses + 1;
            if (prev_vld) vld_long <= vld_long + 1;
            if ((ncyc - last_done_cyc) != 1) bad_vld_gap <= bad_vld_gap + 1;
        end
    end

    task automatic run_read(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] yl,
                            input logic [7:0] yh, input bit stall_h, output int int_lat,
                            output int vld_n, output logic [15:0] p, output logic [15:0] y);
        int c;
        int tail;
        c = 0;
        tail = -1;
        lo_val = lo;
        hi_val = hi;
        yl_val = yl;
        yh_val = yh;
        int_lat = -1;
        vld_n = 0;
        p = 16'h0000;
        y = 16'h0000;
        cmd_log.delete();
        @(posedge clk);
        #1 INT = 1'b1;
        while (c < 300 && tail != 0) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (snd && int_lat < 0) int_lat = c;
            if (snd && cmd == CMD_PTCHL) INT = 1'b0;
            if (snd && cmd == CMD_PTCHH && stall_h) stall = 1'b1;
            if (vld) begin
                vld_n++;
                p = ptch;
`ifdef GYRO_RD_YAW_EN
                y = yaw;
`endif
            end
            if (tail > 0) tail--;
            else if (tail < 0 && (vld || stall)) tail = 6;
        end
    endtask

    task automatic release_and_count(output int n);
        n = 1;
        cmd_log.delete();
        rst = 1'b0;
        while (!snd && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        INT = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (snd !== 1'b0) begin errors++; $display("FAIL reset_snd: got %b expected 0", snd); end
        checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h expected 0000", cmd); end
        checks++; if (ptch !== 16'sh0000) begin errors++; $display("FAIL reset_ptch: got %h expected 0000", ptch); end
        checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", vld); end
    endtask

    task automatic test_powerup();
        int n;
        release_and_count(n);
        checks++; if (n != 17) begin errors++; $display("FAIL pwrup_first_snd_cycle: got %0d expected 17", n); end
        checks++; if (cmd !== CMD_INT_CFG) begin errors++; $display("FAIL pwrup_first_cmd: got %h expected 0d02", cmd); end
    endtask

    task automatic test_config();
        for (int k = 0; k < 400 && cmd_log.size() < 3; k++) @(negedge clk);
        repeat (40) @(negedge clk);
        checks++; if (cmd_log.size() != 3) begin errors++; $display("FAIL cfg_count: got %0d expected 3", cmd_log.size()); end
        if (cmd_log.size() >= 3) begin
            checks++; if (cmd_log[0] !== 16'h0D02) begin errors++; $display("FAIL cfg_cmd0: got %h expected 0d02", cmd_log[0]); end
            checks++; if (cmd_log[1] !== 16'h1160) begin errors++; $display("FAIL cfg_cmd1: got %h expected 1160", cmd_log[1]); end
            checks++; if (cmd_log[2] !== 16'h1440) begin errors++; $display("FAIL cfg_cmd2: got %h expected 1440", cmd_log[2]); end
        end
        checks++; if (nemo_setup !== 1'b1) begin errors++; $display("FAIL cfg_nemo_setup: got %b expected 1", nemo_setup); end
        checks++; if (bad_snd_gap != 0) begin errors++; $display("FAIL cfg_done_to_snd: got %0d bad gaps expected 0", bad_snd_gap); end
        checks++; if (snd_long != 0) begin errors++; $display("FAIL cfg_snd_width: got %0d long pulses expected 0", snd_long); end
    endtask

    task automatic test_first_read();
        int il, vn;
        logic [15:0] p, y;
        run_read(8'h63, 8'h56, 8'h34, 8'h12, 1'b0, il, vn, p, y);
        checks++; if (il != 3) begin errors++; $display("FAIL rd1_int_to_snd: got %0d expected 3", il); end
        checks++; if (cmd_log.size() != NRD) begin errors++; $display("FAIL rd1_nreads: got %0d expected %0d", cmd_log.size(), NRD); end
        if (cmd_log.size() >= NRD) begin
            checks++; if (cmd_log[0] !== 16'hA200) begin errors++; $display("FAIL rd1_cmd0: got %h expected a200", cmd_log[0]); end
            checks++; if (cmd_log[1] !== 16'hA300) begin errors++; $display("FAIL rd1_cmd1: got %h expected a300", cmd_log[1]); end
`ifdef GYRO_RD_YAW_EN
            checks++; if (cmd_log[2] !== 16'hA600) begin errors++; $display("FAIL rd1_cmd2: got %h expected a600", cmd_log[2]); end
            checks++; if (cmd_log[3] !== 16'hA700) begin errors++; $display("FAIL rd1_cmd3: got %h expected a700", cmd_log[3]); end
`endif
        end
        checks++; if (vn != 1) begin errors++; $display("FAIL rd1_vld_count: got %0d expected 1", vn); end
        checks++; if (p !== 16'h5663) begin errors++; $display("FAIL rd1_ptch: got %h expected 5663", p); end
`ifdef GYRO_RD_YAW_EN
        checks++; if (y !== 16'h1234) begin errors++; $display("FAIL rd1_yaw: got %h expected 1234", y); end
`endif
        checks++; if (bad_vld_gap != 0) begin errors++; $display("FAIL rd1_done_to_vld: got %0d bad gaps expected 0", bad_vld_gap); end
        checks++; if (bad_snd_gap != 0) begin errors++; $display("FAIL rd1_done_to_snd: got %0d bad gaps expected 0", bad_snd_gap); end
        checks++; if (vld_long != 0) begin errors++; $display("FAIL rd1_vld_width: got %0d long pulses expected 0", vld_long); end
    endtask

    task automatic test_second_read();
        int il, vn;
        logic [15:0] p, y;
        run_read(8'h21, 8'hCD, 8'h78, 8'h9A, 1'b0, il, vn, p, y);
        checks++; if (vn != 1) begin errors++; $display("FAIL rd2_vld_count: got %0d expected 1", vn); end
        checks++; if (p[15:8] !== 8'hCD) begin errors++; $display("FAIL rd2_ptch_hi: got %h expected cd", p[15:8]); end
        checks++; if (p !== 16'hCD21) begin errors++; $display("FAIL rd2_ptch: got %h expected cd21", p); end
`ifdef GYRO_RD_YAW_EN
        checks++; if (y !== 16'h9A78) begin errors++; $display("FAIL rd2_yaw: got %h expected 9a78", y); end
`endif
    endtask

    task automatic test_back_to_back();
        int nv, a2n, vcyc, gap;
        logic [15:0] p;
        nv = 0; a2n = 0; vcyc = 0; gap = -1; p = 16'h0000;
        lo_val = 8'h01;
        hi_val = 8'h80;
        @(posedge clk);
        #1 INT = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (vld) begin
                nv++;
                vcyc = i;
                p = ptch;
            end
            if (snd && cmd == CMD_PTCHL) begin
                a2n++;
                if (a2n == 2) begin
                    gap = i - vcyc;
                    INT = 1'b0;
                end
            end
            if (nv == 2 && i > vcyc + 8) break;
        end
        INT = 1'b0;
        checks++; if (gap != 2) begin errors++; $display("FAIL b2b_vld_to_snd: got %0d expected 2", gap); end
        checks++; if (nv != 2) begin errors++; $display("FAIL b2b_vld_count: got %0d expected 2", nv); end
        checks++; if (a2n != 2) begin errors++; $display("FAIL b2b_read_count: got %0d expected 2", a2n); end
        checks++; if (p !== 16'h8001) begin errors++; $display("FAIL b2b_ptch: got %h expected 8001", p); end
    endtask

    task automatic test_idle_hold();
        int sp, vp;
        sp = snd_pulses;
        vp = vld_pulses;
        repeat (1000) @(negedge clk);
        checks++; if (snd_pulses != sp) begin errors++; $display("FAIL idle_snd: got %0d pulses expected 0", snd_pulses - sp); end
        checks++; if (vld_pulses != vp) begin errors++; $display("FAIL idle_vld: got %0d pulses expected 0", vld_pulses - vp); end
        checks++; if (cmd !== LAST_CMD) begin errors++; $display("FAIL idle_cmd_hold: got %h expected %h", cmd, LAST_CMD); end
    endtask

    task automatic test_reset_midread();
        int il, vn, n;
        logic [15:0] p, y;
        run_read(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, il, vn, p, y);
        checks++; if (vn != 0) begin errors++; $display("FAIL mid_no_vld: got %0d expected 0", vn); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (snd !== 1'b0) begin errors++; $display("FAIL mid_rst_snd: got %b expected 0", snd); end
        checks++; if (vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld: got %b expected 0", vld); end
        checks++; if (ptch !== 16'sh0000) begin errors++; $display("FAIL mid_rst_ptch: got %h expected 0000", ptch); end
        stall = 1'b0;
        INT = 1'b0;
        release_and_count(n);
        checks++; if (n != 17) begin errors++; $display("FAIL mid_first_snd_cycle: got %0d expected 17", n); end
        checks++; if (cmd !== CMD_INT_CFG) begin errors++; $display("FAIL mid_first_cmd: got %h expected 0d02", cmd); end
        for (int k = 0; k < 400 && cmd_log.size() < 3; k++) @(negedge clk);
        checks++; if (cmd_log.size() != 3) begin errors++; $display("FAIL mid_cfg_count: got %0d expected 3", cmd_log.size()); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_powerup();
        test_config();
        test_first_read();
        test_second_read();
        test_back_to_back();
        repeat (20) @(negedge clk);
        test_idle_hold();
        test_reset_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
